// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] FIX  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: absolute value on operand entry,
// sign restoration on the result path.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with start/ready handshake and annul.
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | one multiply step (MUL_STEP bits) or one quotient bit per cycle
// FIX   | sign correction, hi/lo registered at end of cycle
// DONE  | ready_o high for one cycle; may accept the next op
module iter_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = WIDTH + MUL_STEP;
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(WIDTH / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, ready_q;

  logic               a_neg, b_neg, accept, in_div;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fixed, rem_fixed;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [PW-1:0]      pp, mul_sum;
  logic [WIDTH:0]     shifted, diff;

  assign a_neg  = op_is_signed(op_i) & a_i[WIDTH-1];
  assign b_neg  = op_is_signed(op_i) & b_i[WIDTH-1];
  assign accept = start_i & ~annul_i & ((state_q == IDLE) | (state_q == DONE));
  assign in_div = op_is_div(op_q);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.val_i(a_i), .neg_i(a_neg), .val_o(abs_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.val_i(b_i), .neg_i(b_neg), .val_o(abs_b));
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_res_q), .val_o(prod_fixed));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_fixed));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.val_i(rem_q), .neg_i(neg_rem_q), .val_o(rem_fixed));

  // Multiply step: add multiplicand times the low MUL_STEP multiplier bits to the upper half.
  always_comb begin
    pp      = PW'(mcand_q) * PW'(acc_q[MUL_STEP-1:0]);
    mul_sum = PW'(acc_q[2*WIDTH-1:WIDTH]) + pp;
  end

  // Divide step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted = {rem_q, acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, mcand_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d      = op_i;
          dbz_d     = 1'b0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rem_d     = '0;
          if (op_is_div(op_i)) begin
            mcand_d = abs_b;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            cnt_d   = DIV_ITERS;
          end else begin
            mcand_d = abs_a;
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            cnt_d   = MUL_ITERS;
          end
          if (op_is_div(op_i) && (b_i == '0)) begin
            state_d = DONE;
            hi_d    = a_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (in_div) begin
            if (!diff[WIDTH]) begin
              rem_d = diff[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = shifted[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};
          end
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (in_div) begin
            hi_d = rem_fixed;
            lo_d = quo_fixed;
          end else begin
            {hi_d, lo_d} = prod_fixed;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; busy/ready are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      busy_q    <= (state_d == CALC) || (state_d == FIX);
      ready_q   <= (state_d == DONE);
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign dbz_o   = dbz_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: directed cases plus random ops
// against an arithmetic reference model; second instance uses MUL_STEP=2.
module tb_iter_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start1, start2, annul;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy1, ready1, dbz1, busy2, ready2, dbz2;
  logic [31:0] hi1, lo1, hi2, lo2;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi, exp_lo;
  logic        exp_dbz;

  always #5 clk = ~clk;

  iter_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .a_i(a), .b_i(b),
    .annul_i(annul), .busy_o(busy1), .ready_o(ready1), .dbz_o(dbz1),
    .hi_o(hi1), .lo_o(lo1));

  iter_muldiv_unit #(.WIDTH(32), .MUL_STEP(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .op_i(op), .a_i(a), .b_i(b),
    .annul_i(1'b0), .busy_o(busy2), .ready_o(ready2), .dbz_o(dbz2),
    .hi_o(hi2), .lo_o(lo2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating signed division.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] mh, output logic [31:0] ml, output logic md);
    longint p, sx, sy;
    logic [63:0] up;
    md = 1'b0;
    case (o)
      OP_MULT: begin
        p  = longint'($signed(x)) * longint'($signed(y));
        up = p;
        mh = up[63:32]; ml = up[31:0];
      end
      OP_MULTU: begin
        up = 64'(x) * 64'(y);
        mh = up[63:32]; ml = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          mh = x; ml = 32'hFFFF_FFFF; md = 1'b1;
        end else if (o == OP_DIV) begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          ml = 32'(sx / sy);
          mh = 32'(sx % sy);
        end else begin
          ml = x / y;
          mh = x % y;
        end
      end
    endcase
  endtask

  task automatic wait_ready(input bit s2, input bit hold, output int lat, output int bad);
    lat = 200; bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
      if (s2 ? ready2 : ready1) begin lat = k; break; end
      if (!(s2 ? busy2 : busy1)) bad++;
    end
  endtask

  task automatic check_res(input bit s2, input string tag, input int lat, input int elat,
                           input int bad, input logic [31:0] mh, input logic [31:0] ml,
                           input logic md);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy_during"}, 64'(bad), 64'd0);
    chk({tag, " busy_at_ready"}, 64'(s2 ? busy2 : busy1), 64'd0);
    chk({tag, " hi"}, 64'(s2 ? hi2 : hi1), 64'(mh));
    chk({tag, " lo"}, 64'(s2 ? lo2 : lo1), 64'(ml));
    chk({tag, " dbz"}, 64'(s2 ? dbz2 : dbz1), 64'(md));
  endtask

  task automatic run_op(input bit s2, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    int lat, bad, elat;
    logic [31:0] mh, ml;
    logic md;
    model(o, x, y, mh, ml, md);
    elat = (o[1] && y == 32'd0) ? 1 : (o[1] ? 34 : (s2 ? 18 : 34));
    @(negedge clk);
    op = o; a = x; b = y;
    if (s2) start2 = 1'b1; else start1 = 1'b1;
    wait_ready(s2, 1'b0, lat, bad);
    check_res(s2, tag, lat, elat, bad, mh, ml, md);
    if (!s2) begin exp_hi = mh; exp_lo = ml; exp_dbz = md; end
    @(posedge clk); #1;
    chk({tag, " ready_pulse"}, 64'(s2 ? ready2 : ready1), 64'd0);
  endtask

  initial begin
    int lat, bad;
    logic [31:0] mh, ml, x, y;
    logic md;
    logic [1:0] o;

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; annul = 1'b0;
    op = OP_MULT; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy1), 64'd0);
    chk("rst ready", 64'(ready1), 64'd0);
    chk("rst dbz", 64'(dbz1), 64'd0);
    chk("rst hi", 64'(hi1), 64'd0);
    chk("rst lo", 64'(lo1), 64'd0);
    chk("rst2 ready", 64'(ready2), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_op(0, OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    chk("mult_neg hi literal", 64'(hi1), 64'hFFFF_FFFF);
    chk("mult_neg lo literal", 64'(lo1), 64'hFFFF_FFEB);
    run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg lo literal", 64'(lo1), 64'hFFFF_FFFD);
    run_op(0, OP_DIVU, 32'd7, 32'd2, "divu_7_2");
    run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    chk("div_min_m1 lo literal", 64'(lo1), 64'h8000_0000);
    run_op(0, OP_DIVU, 32'd5, 32'd0, "divu_dbz");
    run_op(0, OP_MULT, 32'd6, 32'hFFFF_FFFE, "mult_after_dbz");

    // annul in cycle 10 of a DIV
    @(negedge clk);
    op = OP_DIV; a = 32'd1000; b = 32'd7; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    @(posedge clk); #1;
    chk("annul busy", 64'(busy1), 64'd0);
    chk("annul ready", 64'(ready1), 64'd0);
    @(negedge clk) annul = 1'b0;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready1 || busy1) bad++;
    end
    chk("annul quiet", 64'(bad), 64'd0);
    chk("annul hi held", 64'(hi1), 64'(exp_hi));
    chk("annul lo held", 64'(lo1), 64'(exp_lo));
    chk("annul dbz held", 64'(dbz1), 64'(exp_dbz));
    run_op(0, OP_MULTU, 32'd3, 32'd4, "multu_after_annul");

    // annul in IDLE blocks acceptance
    @(negedge clk);
    op = OP_MULTU; a = 32'd1; b = 32'd1; start1 = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    chk("idle_annul busy", 64'(busy1), 64'd0);
    @(negedge clk) begin start1 = 1'b0; annul = 1'b0; end
    @(posedge clk); #1;
    chk("idle_annul ready", 64'(ready1), 64'd0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: x = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(0, o, x, y, $sformatf("rand%0d", i));
    end

    // MUL_STEP=2 instance
    run_op(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "s2_multu_max");
    run_op(1, OP_MULT, 32'hFFFF_FFFD, 32'd7, "s2_mult_neg");
    for (int i = 0; i < 8; i++)
      run_op(1, 2'($urandom_range(0, 1)), $urandom, $urandom, $sformatf("s2_rand%0d", i));

    // back-to-back with start_i held high; operand changes during CALC ignored
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd9; start1 = 1'b1;
    model(OP_DIVU, 32'd100, 32'd9, mh, ml, md);
    wait_ready(0, 1'b1, lat, bad);
    check_res(0, "b2b_first", lat, 34, bad, mh, ml, md);
    op = OP_MULT; a = 32'hFFFF_0001; b = 32'd12345;
    model(OP_MULT, 32'hFFFF_0001, 32'd12345, mh, ml, md);
    @(posedge clk); #1;
    op = OP_DIVU; a = $urandom; b = 32'd0;
    wait_ready(0, 1'b1, lat, bad);
    start1 = 1'b0;
    check_res(0, "b2b_second", lat + 1, 34, bad, mh, ml, md);
    @(posedge clk); #1;
    chk("b2b no reaccept busy", 64'(busy1), 64'd0);
    chk("b2b no reaccept ready", 64'(ready1), 64'd0);

    // reset mid-CALC
    @(negedge clk);
    op = OP_MULTU; a = 32'd77; b = 32'd99; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", 64'(busy1), 64'd0);
    chk("midrst ready", 64'(ready1), 64'd0);
    chk("midrst dbz", 64'(dbz1), 64'd0);
    chk("midrst hi", 64'(hi1), 64'd0);
    chk("midrst lo", 64'(lo1), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst stays idle", 64'(busy1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
